// File: rtl/hazard_flush_ctrl_if.sv
// Hazard controller bundle: ID/EX hazard inputs, memory busy, and the
// stall/squash/freeze controls returned to the pipeline.
//   master : pipeline side (drives hazard inputs, consumes controls)
//   slave  : hazard_flush_ctrl (consumes hazard inputs, drives controls)
interface hazard_flush_ctrl_if #(
  parameter int unsigned REG_W = 5,
  parameter int unsigned CNT_W = 16
);
  logic             id_valid;
  logic [REG_W-1:0] id_rs;
  logic [REG_W-1:0] id_rt;
  logic             id_uses_rt;
  logic             ex_memread;
  logic [REG_W-1:0] ex_rd;
  logic             ex_branch_taken;
  logic             mem_busy;
  logic             pc_write;
  logic             ifid_write;
  logic             ifid_flush;
  logic             flush;
  logic             pipe_freeze;
  logic [1:0]       state;
  logic [CNT_W-1:0] stall_count;

  modport master (
    output id_valid, id_rs, id_rt, id_uses_rt, ex_memread, ex_rd,
           ex_branch_taken, mem_busy,
    input  pc_write, ifid_write, ifid_flush, flush, pipe_freeze, state,
           stall_count
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_uses_rt, ex_memread, ex_rd,
           ex_branch_taken, mem_busy,
    output pc_write, ifid_write, ifid_flush, flush, pipe_freeze, state,
           stall_count
  );
endinterface

// File: rtl/hazard_flush_ctrl.sv
// Pipeline hazard controller for the 5-stage KGP RISC core.
// Detects load-use hazards (one bubble), sequences the branch squash window
// and freezes the pipeline while data memory is busy.
// Ports:
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : hazard_flush_ctrl_if.slave (hazard inputs in, controls out)
// Controls are combinational from state and inputs; state and stall_count
// are registered.
module hazard_flush_ctrl #(
  parameter int unsigned REG_W        = 5,
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned CNT_W        = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  hazard_flush_ctrl_if.slave bus
);

  localparam int unsigned BC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [BC_W-1:0] BC_RELOAD = BC_W'(FLUSH_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_BR_FLUSH = 2'd1,
    ST_MEM_WAIT = 2'd2
  } state_e;

  state_e           r_state;
  state_e           r_saved;
  logic [BC_W-1:0]  r_bcnt;
  logic [CNT_W-1:0] r_stall_count;

  state_e           w_state_nxt;
  state_e           w_saved_nxt;
  state_e           w_eff;
  logic [BC_W-1:0]  w_bcnt_nxt;
  logic [REG_W-1:0] w_ex_rd;
  logic             w_hz;
  logic             w_pc_write;
  logic             w_ifid_write;
  logic             w_ifid_flush;
  logic             w_flush;
  logic             w_pipe_freeze;

  // Load-use hazard: EX load writes a register the ID instruction reads.
  assign w_ex_rd = bus.ex_rd;
  assign w_hz = bus.id_valid & bus.ex_memread & (w_ex_rd != '0) &
                ((w_ex_rd == bus.id_rs) | (bus.id_uses_rt & (w_ex_rd == bus.id_rt)));

  // While waiting on memory, behave as the state that was interrupted.
  assign w_eff = (r_state == ST_MEM_WAIT) ? r_saved : r_state;

  // Next-state and control outputs; priority mem_busy > branch > hazard.
  always_comb begin
    w_pc_write    = 1'b1;
    w_ifid_write  = 1'b1;
    w_ifid_flush  = 1'b0;
    w_flush       = 1'b0;
    w_pipe_freeze = 1'b0;
    w_state_nxt   = r_state;
    w_saved_nxt   = r_saved;
    w_bcnt_nxt    = r_bcnt;

    if (bus.mem_busy) begin
      w_pipe_freeze = 1'b1;
      w_pc_write    = 1'b0;
      w_ifid_write  = 1'b0;
      w_state_nxt   = ST_MEM_WAIT;
      if (r_state != ST_MEM_WAIT) begin
        w_saved_nxt = r_state;
      end
    end else begin
      case (w_eff)
        ST_BR_FLUSH: begin
          w_ifid_flush = 1'b1;
          w_flush      = 1'b1;
          if (bus.ex_branch_taken) begin
            w_bcnt_nxt  = BC_RELOAD;
            w_state_nxt = ST_BR_FLUSH;
          end else begin
            w_bcnt_nxt  = r_bcnt - BC_W'(1);
            w_state_nxt = (r_bcnt == BC_W'(1)) ? ST_RUN : ST_BR_FLUSH;
          end
        end
        default: begin
          w_state_nxt = ST_RUN;
          if (bus.ex_branch_taken) begin
            w_ifid_flush = 1'b1;
            w_flush      = 1'b1;
            if (FLUSH_CYCLES > 1) begin
              w_bcnt_nxt  = BC_RELOAD;
              w_state_nxt = ST_BR_FLUSH;
            end
          end else if (w_hz) begin
            w_pc_write   = 1'b0;
            w_ifid_write = 1'b0;
            w_flush      = 1'b1;
          end
        end
      endcase
    end

    // Reset holds the front end stalled and squashed.
    if (!rst_n) begin
      w_pc_write    = 1'b0;
      w_ifid_write  = 1'b0;
      w_ifid_flush  = 1'b1;
      w_flush       = 1'b1;
      w_pipe_freeze = 1'b0;
    end
  end

  // State, saved state, branch counter and saturating stall counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_RUN;
      r_saved       <= ST_RUN;
      r_bcnt        <= '0;
      r_stall_count <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_saved <= w_saved_nxt;
      r_bcnt  <= w_bcnt_nxt;
      if (!w_pc_write && !(&r_stall_count)) begin
        r_stall_count <= r_stall_count + CNT_W'(1);
      end
    end
  end

  assign bus.pc_write    = w_pc_write;
  assign bus.ifid_write  = w_ifid_write;
  assign bus.ifid_flush  = w_ifid_flush;
  assign bus.flush       = w_flush;
  assign bus.pipe_freeze = w_pipe_freeze;
  assign bus.state       = 2'(r_state);
  assign bus.stall_count = r_stall_count;

endmodule

// File: doc/hazard_flush_ctrl.md
# hazard_flush_ctrl

Pipeline hazard controller for the 5-stage KGP RISC core. Each cycle it decides whether to stall fetch and decode, squash instructions, or freeze the whole pipeline. It detects load-use hazards, sequences the multi-cycle branch squash window and holds the pipeline while data memory is busy. Its `flush` output drives the control-zeroing stage between the ID control decoder and the ID/EX register.

## Interface
Parameters:
- `REG_W`, 5: register-specifier width.
- `FLUSH_CYCLES`, 2: total cycles of fetch squash after a taken branch (≥1).
- `CNT_W`, 16: stall performance counter width.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `id_valid`  in  1  ID stage holds a real instruction.
- `id_rs`  in  REG_W  ID source register 1.
- `id_rt`  in  REG_W  ID source register 2.
- `id_uses_rt`  in  1  ID instruction reads `id_rt`.
- `ex_memread`  in  1  EX instruction is a load.
- `ex_rd`  in  REG_W  EX destination register.
- `ex_branch_taken`  in  1  branch/jump resolved taken in EX this cycle.
- `mem_busy`  in  1  data memory not ready.
- `pc_write`  out  1  PC update enable.
- `ifid_write`  out  1  IF/ID register load enable.
- `ifid_flush`  out  1  clear IF/ID to a bubble.
- `flush`  out  1  zero ID-stage control fields entering ID/EX.
- `pipe_freeze`  out  1  hold ID/EX, EX/MEM and MEM/WB.
- `state`  out  2  FSM state: RUN=0, BR_FLUSH=1, MEM_WAIT=2.
- `stall_count`  out  CNT_W  saturating count of cycles with `pc_write`=0.

## Operation
- `hz` = `id_valid` & `ex_memread` & (`ex_rd`≠0) & ((`ex_rd`==`id_rs`) | (`id_uses_rt` & `ex_rd`==`id_rt`)).
- Outputs are combinational from state and inputs. Event priority is `mem_busy` > `ex_branch_taken` > `hz`.
- Default outputs (no event): `pc_write`=1, `ifid_write`=1, all other outputs 0.
- `mem_busy`=1 in any state:
  - Outputs: `pipe_freeze`=1, `pc_write`=0, `ifid_write`=0, `flush`=0, `ifid_flush`=0.
  - Next state MEM_WAIT. The pre-freeze state and branch counter are saved unchanged.
- MEM_WAIT with `mem_busy`=0:
  - Outputs are those of the saved state for this cycle.
  - Next state is the saved state, or the result of that state's transitions if it acts on an event this cycle.
- RUN with `ex_branch_taken`:
  - Outputs: `pc_write`=1 (target loads), `ifid_flush`=1, `flush`=1.
  - If FLUSH_CYCLES>1: load counter with FLUSH_CYCLES−1 and go to BR_FLUSH. Otherwise stay in RUN.
  - A simultaneous `hz` is ignored.
- RUN with `hz` only:
  - Outputs: `pc_write`=0, `ifid_write`=0, `flush`=1 (one bubble).
  - Stay in RUN. The hazard clears when the load advances.
- BR_FLUSH:
  - Outputs: `ifid_flush`=1, `flush`=1, `pc_write`=1. `hz` is ignored (ID is squashed).
  - Counter decrements each non-frozen cycle. Go to RUN in the cycle the counter reads 1.
  - A new `ex_branch_taken` reloads the counter with FLUSH_CYCLES−1 and is treated as a new branch.
- `stall_count`:
  - +1 on every non-reset edge where `pc_write`=0. This covers both load-use and MEM_WAIT cycles.
  - Saturates at 2^CNT_W−1 and never wraps.

## Timing
- Reset (`rst_n`=0, asynchronous):
  - Registers: state=RUN, counter=0, saved state=RUN, `stall_count`=0.
  - Outputs forced while asserted: `pc_write`=0, `ifid_write`=0, `ifid_flush`=1, `flush`=1, `pipe_freeze`=0.
  - Reset mid-BR_FLUSH or mid-MEM_WAIT abandons the sequence. After deassertion the block is in RUN.
- Load-use: zero-latency stall in the detection cycle, exactly one bubble per hazard.
- Taken branch: squash asserted in the resolution cycle plus FLUSH_CYCLES−1 following non-frozen cycles.
- Freeze cycles do not count toward the squash window.
- `state` reflects the registered FSM and updates on the rising `clk` edge.

## Test plan
- Load-use: `ex_memread`=1, `ex_rd`=3, `id_rs`=3, `id_valid`=1 for one cycle → that cycle `pc_write`=0, `ifid_write`=0, `flush`=1; next cycle defaults; `stall_count`=1. Repeat with `ex_rd`=0 → no stall.
- Branch, FLUSH_CYCLES=2: `ex_branch_taken` pulse at cycle T → `ifid_flush`=`flush`=1 at T and T+1; `state`=1 after T; RUN after T+1.
- Simultaneous branch and load-use at T → `pc_write`=1, squash asserted, `stall_count` unchanged.
- `mem_busy` high for 3 cycles during BR_FLUSH (counter=1) → `pipe_freeze`=1 and squash=0 for 3 cycles, `state`=2, `stall_count`+3; then one squash cycle, then RUN.
- Reset asserted mid-BR_FLUSH → outputs immediately at reset values, `stall_count`=0; after release `state`=0.
- CNT_W=4: 20 consecutive `mem_busy` cycles → `stall_count` holds at 15.
